// File: rtl/carrysel_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional signed-overflow output enabled by defining CARRYSEL_OVF_EN.
module carrysel_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CARRYSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / BLOCK;
  localparam logic [BLOCK:0] L_ONE = (BLOCK + 1)'(1);

  generate
    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("carrysel_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic             w_accept;
  logic             w_s1_adv;
  logic [BLOCK:0]   w_cand0 [NSEG];
  logic [BLOCK:0]   w_cand1 [NSEG];

  logic             r_s1_valid;
  logic             r_c0;
  logic [BLOCK:0]   r_s0 [NSEG];
  logic [BLOCK:0]   r_s1 [NSEG];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_carry_top;

  assign w_bx     = b ^ {WIDTH{sub}};
  assign w_c0     = cin ^ sub;
  assign w_s1_adv = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_s1_adv;
  assign w_accept = in_valid & in_ready;

  // Both carry-in candidates per segment; the chain in stage 2 picks one.
  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      logic [BLOCK-1:0] w_as;
      logic [BLOCK-1:0] w_bs;
      assign w_as        = a[gi*BLOCK +: BLOCK];
      assign w_bs        = w_bx[gi*BLOCK +: BLOCK];
      assign w_cand0[gi] = {1'b0, w_as} + {1'b0, w_bs};
      assign w_cand1[gi] = {1'b0, w_as} + {1'b0, w_bs} + L_ONE;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_c0 <= w_c0;
      for (int k = 0; k < NSEG; k++) begin
        r_s0[k] <= w_cand0[k];
        r_s1[k] <= w_cand1[k];
      end
    end
  end

  always_comb begin
    w_sum       = '0;
    w_carry     = r_c0;
    w_carry_top = r_c0;
    for (int k = 0; k < NSEG; k++) begin
      if (k == NSEG - 1) w_carry_top = w_carry;
      w_sum[k*BLOCK +: BLOCK] = w_carry ? r_s1[k][BLOCK-1:0] : r_s0[k][BLOCK-1:0];
      w_carry                 = w_carry ? r_s1[k][BLOCK]     : r_s0[k][BLOCK];
    end
  end

`ifdef CARRYSEL_OVF_EN
  // Carry into the MSB for each candidate carry-in of the top segment.
  logic w_cm0;
  logic w_cm1;
  logic r_cm0;
  logic r_cm1;
  logic r_ovf;

  generate
    if (BLOCK == 1) begin : g_cm_bit
      assign w_cm0 = 1'b0;
      assign w_cm1 = 1'b1;
    end else begin : g_cm_low
      logic [BLOCK-1:0] w_low0;
      logic [BLOCK-1:0] w_low1;
      assign w_low0 = {1'b0, a[(NSEG-1)*BLOCK +: BLOCK-1]} + {1'b0, w_bx[(NSEG-1)*BLOCK +: BLOCK-1]};
      assign w_low1 = w_low0 + BLOCK'(1);
      assign w_cm0  = w_low0[BLOCK-1];
      assign w_cm1  = w_low1[BLOCK-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cm0 <= w_cm0;
      r_cm1 <= w_cm1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_s1_adv) begin
      r_ovf <= (w_carry_top ? r_cm1 : r_cm0) ^ w_carry;
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_cout      <= w_carry;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_carrysel_pipe_adder.sv
// Bench for carrysel_pipe_adder: 64/8 and 16/4 instances in lockstep, checked by an
// arithmetic scoreboard plus directed vectors for latency, stall and reset corners.
module tb_carrysel_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        in_ready, out_valid, cout;
  logic [63:0] sum;
  logic        in_ready2, out_valid2, cout2;
  logic [15:0] sum2;
`ifdef CARRYSEL_OVF_EN
  logic        ovf, ovf2;
`endif

  always #5 clk = ~clk;

  carrysel_pipe_adder #(.WIDTH(64), .BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CARRYSEL_OVF_EN
    , .ovf(ovf)
`endif
  );

  carrysel_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2)
`ifdef CARRYSEL_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct {
    logic [63:0] s;  logic c;  logic o;
    logic [15:0] s2; logic c2; logic o2;
  } exp_t;

  typedef struct {
    logic [63:0] a; logic [63:0] b; logic cin; logic sub;
    logic [63:0] es; logic ec; logic eo;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Plain modular arithmetic; subtraction is a - b - cin with cout = "no borrow".
  function automatic void model(input logic [63:0] ai, input logic [63:0] bi,
                                input logic ci, input logic si, input int w,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask;
    logic [64:0] full;
    logic [63:0] aa, bb;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa   = ai & mask;
    bb   = bi & mask;
    if (!si) full = {1'b0, aa} + {1'b0, bb} + 65'(ci);
    else     full = {1'b0, aa} + {1'b0, mask - bb} + 65'(!ci);
    s  = full[63:0] & mask;
    co = full[w];
    if (!si) ov = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    else     ov = (aa[w-1] != bb[w-1]) && (s[w-1] != aa[w-1]);
  endfunction

  logic        prev_stall = 1'b0;
  logic [63:0] prev_sum = '0;
  logic [15:0] prev_sum2 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      chk("in_ready_w16", 64'(in_ready2), 64'(in_ready));
      chk("out_valid_w16", 64'(out_valid2), 64'(out_valid));
      if (prev_stall) begin
        chk("stall_hold_sum", sum, prev_sum);
        chk("stall_hold_sum_w16", 64'(sum2), 64'(prev_sum2));
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_sum2  = sum2;
      if (out_valid && out_ready) begin
        n_out++;
        $display("result #%0d sum=%h cout=%0b sum16=%h cout16=%0b", n_out, sum, cout, sum2, cout2);
        if (sb_q.size() == 0) begin
          chk("spurious_output", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", 64'(cout), 64'(e.c));
          chk("sum_w16", 64'(sum2), 64'(e.s2));
          chk("cout_w16", 64'(cout2), 64'(e.c2));
`ifdef CARRYSEL_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.o));
          chk("ovf_w16", 64'(ovf2), 64'(e.o2));
`endif
        end
      end
      if (in_valid && in_ready) begin
        logic [63:0] s16;
        model(a, b, cin, sub, 64, e.s, e.c, e.o);
        model(a, b, cin, sub, 16, s16, e.c2, e.o2);
        e.s2 = s16[15:0];
        sb_q.push_back(e);
      end
    end
  end

  task automatic drive_rand();
    a   = {$urandom(), $urandom()};
    b   = ($urandom_range(0, 3) == 0) ? ~a : {$urandom(), $urandom()};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic run_row(input vec_t v, input int idx);
    chk($sformatf("row%0d_pre_in_ready", idx), 64'(in_ready), 64'(1));
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("row%0d_lat1_out_valid", idx), 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk($sformatf("row%0d_lat2_out_valid", idx), 64'(out_valid), 64'(1));
    chk($sformatf("row%0d_sum", idx), sum, v.es);
    chk($sformatf("row%0d_cout", idx), 64'(cout), 64'(v.ec));
`ifdef CARRYSEL_OVF_EN
    chk($sformatf("row%0d_ovf", idx), 64'(ovf), 64'(v.eo));
`endif
    @(posedge clk); #1;
  endtask

  vec_t vt[11];

  initial begin
    logic [63:0] held;
    int          base;
    vt[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[2]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    vt[3]  = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0};
    vt[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[5]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[6]  = '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
    vt[7]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vt[8]  = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 64'h0100_0100_0100_0100, 1'b0, 1'b0};
    vt[9]  = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
    vt[10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_sum", sum, 64'd0);
    chk("reset_cout", 64'(cout), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_row(vt[i], i);

    // Back-to-back stream: no bubbles once the pipe has filled.
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      in_valid = 1'b1;
      chk("b2b_in_ready", 64'(in_ready), 64'(1));
      chk("b2b_out_valid", 64'(out_valid), 64'(i >= 2));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_result_count", 64'(n_out - base), 64'd16);

    // Stall with three attempted accepts: only two fit.
    out_ready = 1'b0;
    drive_rand(); in_valid = 1'b1;
    chk("stall_accept1_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    drive_rand();
    chk("stall_accept2_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    drive_rand();
    chk("stall_full_in_ready", 64'(in_ready), 64'(0));
    chk("stall_full_out_valid", 64'(out_valid), 64'(1));
    held = sum;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready_low", 64'(in_ready), 64'(0));
      chk("stall_sum_stable", sum, held);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_drained", 64'(sb_q.size()), 64'd0);
    chk("stall_idle_out_valid", 64'(out_valid), 64'(0));

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    drive_rand(); in_valid = 1'b1;
    @(posedge clk); #1;
    drive_rand();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'(0));
    chk("async_reset_sum", sum, 64'd0);
    chk("async_reset_in_ready", 64'(in_ready), 64'(1));
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_stale_out_valid", 64'(out_valid), 64'(0));
    end
    run_row(vt[0], 100);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      drive_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("random_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
